// File: rtl/ysyx_pkg.sv
// rtl/ysyx_pkg.sv - shared types and constants for the instruction fetch unit
package ysyx_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } ifu_state_t;

endpackage

// File: rtl/ysyx_ifu.sv
// rtl/ysyx_ifu.sv - single-outstanding instruction fetch unit with redirect squashing
module ysyx_ifu
  import ysyx_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  ifu_state_t  state;
  logic [31:0] fetch_pc;
  logic        drop;
  logic        rst_q;
  logic        req_fire;
  logic [31:0] redirect_target;

  // rst_q keeps the request low until the first edge after reset is released
  assign imem_req_valid  = rst_q && (state == REQ);
  assign imem_req_addr   = fetch_pc;
  assign inst_valid      = (state == HOLD);
  assign req_fire        = imem_req_valid && imem_req_ready;
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= REQ;
      fetch_pc <= RESET_PC;
      drop     <= 1'b0;
      rst_q    <= 1'b0;
      inst     <= 32'h0;
      pc       <= RESET_PC;
    end else begin
      rst_q <= 1'b1;
      case (state)
        REQ: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_target;
            if (req_fire) begin
              // the request just accepted targets the old path
              state <= WAIT;
              drop  <= 1'b1;
            end
          end else if (req_fire) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (imem_resp_valid) begin
            if (redirect_valid) begin
              fetch_pc <= redirect_target;
              drop     <= 1'b0;
              state    <= REQ;
            end else if (drop) begin
              drop  <= 1'b0;
              state <= REQ;
            end else begin
              inst  <= imem_resp_data;
              pc    <= fetch_pc;
              state <= HOLD;
            end
          end else if (redirect_valid) begin
            fetch_pc <= redirect_target;
            drop     <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_target;
            state    <= REQ;
          end else if (inst_ready) begin
            fetch_pc <= fetch_pc + 32'd4;
            state    <= REQ;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_ifu.sv
// tb/tb_ysyx_ifu.sv - scoreboard bench for ysyx_ifu with directed and random fetch traffic
module tb_ysyx_ifu;
  import ysyx_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  ysyx_ifu #(.RESET_PC(RESET_PC_DEFAULT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .pc             (pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  int n_chk = 0;
  int n_err = 0;

  // architectural model: the address of the next instruction decode should see
  logic [31:0] next_pc;
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;

  // memory model state
  logic        pend;
  logic        bad_next;
  logic [31:0] pend_addr;
  int          lat_cnt;
  int          lat_cfg = 1;
  bit          rnd = 1'b0;
  int          cyc = 0;

  logic [31:0] req_addr_q[$];
  int          req_cyc_q[$];
  logic [31:0] cons_pc_q[$];
  logic [31:0] hp;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    next_pc = RESET_PC_DEFAULT;
    exp_q.delete();
    exp_q.push_back(RESET_PC_DEFAULT);
    pend            = 1'b0;
    bad_next        = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = INST_NOP;
  endtask

  task automatic clear_log();
    req_addr_q.delete();
    req_cyc_q.delete();
    cons_pc_q.delete();
  endtask

  // one clock cycle: memory model, stimulus, then model update; returns just after the edge
  task automatic step(input logic rv, input logic [31:0] rt, input logic ir);
    logic ihs;
    @(negedge clk);
    cyc++;
    imem_resp_valid = 1'b0;
    imem_resp_data  = INST_NOP;
    if (pend) begin
      if (lat_cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = bad_next ? 32'hDEAD_BEEF : mem_word(pend_addr);
        pend     = 1'b0;
        bad_next = 1'b0;
      end else begin
        lat_cnt--;
      end
    end
    imem_req_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    inst_ready     = ir;
    redirect_valid = rv;
    redirect_pc    = rt;
    if (imem_req_valid && imem_req_ready) begin
      pend      = 1'b1;
      pend_addr = imem_req_addr;
      lat_cnt   = (rnd ? int'($urandom_range(1, 3)) : lat_cfg) - 1;
      req_addr_q.push_back(imem_req_addr);
      req_cyc_q.push_back(cyc);
    end
    ihs = inst_valid && inst_ready;
    if (ihs) cons_pc_q.push_back(pc);
    #2;
    if (rv) begin
      next_pc = {rt[31:2], 2'b00};
      exp_q.delete();
      exp_q.push_back(next_pc);
    end else if (ihs) begin
      next_pc = next_pc + 32'd4;
      exp_q.push_back(next_pc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic go_req();
    for (int n = 0; n < 20 && !imem_req_valid; n++) step(1'b0, 32'h0, 1'b1);
    check("reach_req", {31'h0, imem_req_valid}, 32'h1);
  endtask

  task automatic go_hold();
    for (int n = 0; n < 20 && !inst_valid; n++) step(1'b0, 32'h0, 1'b0);
    check("reach_hold", {31'h0, inst_valid}, 32'h1);
  endtask

  // monitor: compares every request and every consumed instruction against the model
  always @(negedge clk) begin
    #1;
    if (rst_n === 1'b1) begin
      if (imem_req_valid) check("req_addr", imem_req_addr, next_pc);
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_inst: actual pc=%h expected no delivery", pc);
        end else begin
          mon_e = exp_q.pop_front();
          check("pc", pc, mon_e);
          check("inst", inst, mem_word(mon_e));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    model_reset();
    #12;
    check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
    check("rst_pc", pc, RESET_PC_DEFAULT);
    check("rst_inst", inst, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("req_gated_after_release", {31'h0, imem_req_valid}, 32'h0);
    @(posedge clk);
    #1;
    check("req_first_edge", {31'h0, imem_req_valid}, 32'h1);

    // first fetch, 1-cycle memory, decode always ready
    clear_log();
    repeat (7) step(1'b0, 32'h0, 1'b1);
    check("first_req_addr", req_addr_q[0], 32'h8000_0000);
    check("second_req_addr", req_addr_q[1], 32'h8000_0004);
    check("req_spacing", req_cyc_q[1] - req_cyc_q[0], 32'd3);
    check("first_pc", cons_pc_q[0], 32'h8000_0000);

    // decode stall
    go_hold();
    hp = next_pc;
    repeat (5) begin
      step(1'b0, 32'h0, 1'b0);
      check("stall_valid", {31'h0, inst_valid}, 32'h1);
      check("stall_inst", inst, mem_word(hp));
      check("stall_noreq", {31'h0, imem_req_valid}, 32'h0);
    end
    clear_log();
    step(1'b0, 32'h0, 1'b1);
    for (int n = 0; n < 10 && req_addr_q.size() == 0; n++) step(1'b0, 32'h0, 1'b0);
    check("after_stall_addr", req_addr_q[0], hp + 32'd4);

    // redirect while waiting; the late response is poisoned
    go_req();
    lat_cfg  = 3;
    bad_next = 1'b1;
    step(1'b0, 32'h0, 1'b1);
    lat_cfg = 1;
    clear_log();
    step(1'b1, 32'h8000_0100, 1'b1);
    repeat (8) step(1'b0, 32'h0, 1'b1);
    check("wait_redir_addr", req_addr_q[0], 32'h8000_0100);
    check("wait_redir_pc", cons_pc_q[0], 32'h8000_0100);

    // redirect coinciding with request acceptance
    go_req();
    clear_log();
    step(1'b1, 32'h8000_0203, 1'b1);
    repeat (8) step(1'b0, 32'h0, 1'b1);
    check("hs_redir_addr", req_addr_q[1], 32'h8000_0200);
    check("hs_redir_gap", req_cyc_q[1] - req_cyc_q[0], 32'd2);
    check("hs_redir_pc", cons_pc_q[0], 32'h8000_0200);

    // redirect in HOLD with decode consuming the same cycle
    go_hold();
    hp = next_pc;
    clear_log();
    step(1'b1, 32'h8000_0400, 1'b1);
    check("hold_redir_valid_falls", {31'h0, inst_valid}, 32'h0);
    check("hold_redir_consumed", cons_pc_q[0], hp);
    repeat (4) step(1'b0, 32'h0, 1'b1);
    check("hold_redir_addr", req_addr_q[0], 32'h8000_0400);

    // address wrap
    go_req();
    step(1'b1, 32'hFFFF_FFFC, 1'b1);
    clear_log();
    repeat (8) step(1'b0, 32'h0, 1'b1);
    check("wrap_first", req_addr_q[0], 32'hFFFF_FFFC);
    check("wrap_next", req_addr_q[1], 32'h0000_0000);
    check("wrap_pc", cons_pc_q[0], 32'hFFFF_FFFC);

    // asynchronous reset while a request is outstanding
    go_req();
    lat_cfg = 3;
    step(1'b0, 32'h0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check("async_rst_inst_valid", {31'h0, inst_valid}, 32'h0);
    check("async_rst_pc", pc, RESET_PC_DEFAULT);
    check("async_rst_inst", inst, 32'h0);
    model_reset();
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    lat_cfg        = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    repeat (4) step(1'b0, 32'h0, 1'b1);
    check("restart_addr", req_addr_q[0], RESET_PC_DEFAULT);

    // random traffic: memory stalls and latency, decode stalls, redirects
    rnd = 1'b1;
    repeat (3000) step($urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 3) != 0);
    rnd = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
